// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight destinations (EX/MEM/WB), raises
// stall/bubble/flush/freeze controls, registers EX forwarding selects and counts events.
module pipeline_hazard_ctrl #(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_reg_wb,
   input  logic             id_is_load,
   input  logic             ex_redirect,
   input  logic             mem_busy,
   output logic             pc_stall,
   output logic             ifid_stall,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             freeze,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [1:0]       ctrl_state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             wb;
      logic             load;
   } slot_t;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_LSTALL = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_FREEZE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
   logic             load_use, sel_stall, sel_flush;

   function automatic logic match(input logic [REG_W-1:0] rs, input slot_t s);
      return s.valid && s.wb && (s.rd != '0) && (s.rd == rs);
   endfunction

   // EX/MEM forward beats MEM/WB; a load in EX never forwards (it forces a bubble instead)
   function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [REG_W-1:0] rs,
                                          input slot_t ex, input slot_t mem);
      if (use_rs && match(rs, ex) && !ex.load) return 2'b10;
      if (use_rs && match(rs, mem))            return 2'b01;
      return 2'b00;
   endfunction

   assign load_use = id_valid &&
                     ((id_use_rs1 && match(id_rs1, ex_q) && ex_q.load) ||
                      (id_use_rs2 && match(id_rs2, ex_q) && ex_q.load));

   // Priority control decode: busy > redirect > load-use > run
   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      freeze      = 1'b0;
      sel_stall   = 1'b0;
      sel_flush   = 1'b0;
      state_d     = ST_RUN;
      if (reset) begin
         state_d = ST_RUN;
      end else if (mem_busy) begin
         freeze     = 1'b1;
         pc_stall   = 1'b1;
         ifid_stall = 1'b1;
         state_d    = ST_FREEZE;
      end else if (ex_redirect) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         sel_flush   = 1'b1;
         state_d     = ST_FLUSH;
      end else if (load_use) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_bubble = 1'b1;
         sel_stall   = 1'b1;
         state_d     = ST_LSTALL;
      end
   end

   // Scoreboard shift, forwarding selects and saturating counters; all hold while frozen
   always_comb begin
      ex_d        = ex_q;
      mem_d       = mem_q;
      wb_d        = wb_q;
      fwd_a_d     = fwd_a_q;
      fwd_b_d     = fwd_b_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!freeze) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         if (idex_bubble || !id_valid) begin
            ex_d = '0;
         end else begin
            ex_d.valid = 1'b1;
            ex_d.rd    = id_rd;
            ex_d.wb    = id_reg_wb;
            ex_d.load  = id_is_load;
         end
         fwd_a_d = idex_bubble ? 2'b00 : fwd_sel(id_use_rs1, id_rs1, ex_q, mem_q);
         fwd_b_d = idex_bubble ? 2'b00 : fwd_sel(id_use_rs2, id_rs2, ex_q, mem_q);
         if (sel_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (sel_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_RUN;
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         fwd_a_q     <= 2'b00;
         fwd_b_q     <= 2'b00;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         fwd_a_q     <= fwd_a_d;
         fwd_b_q     <= fwd_b_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // WB slot tracks occupancy only; nothing in this block consumes it
   logic wb_unused;
   assign wb_unused = ^wb_q;

   assign fwd_a      = fwd_a_q;
   assign fwd_b      = fwd_b_q;
   assign ctrl_state = state_q;
   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expectations queued per step, combinational
// controls checked mid-cycle, registered outputs checked after the following edge.
module tb_pipeline_hazard_ctrl;
   localparam int unsigned REG_W = 5;
   localparam int unsigned CNT_W = 4;
   localparam logic [4:0] C0  = 5'b00000;
   localparam logic [4:0] STL = 5'b11010;
   localparam logic [4:0] FLS = 5'b00110;
   localparam logic [4:0] FRZ = 5'b11001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, id_valid, id_use_rs1, id_use_rs2, id_reg_wb, id_is_load, ex_redirect, mem_busy;
   logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
   logic pc_stall, ifid_stall, ifid_flush, idex_bubble, freeze;
   logic [1:0] fwd_a, fwd_b, ctrl_state;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_wb(id_reg_wb),
      .id_is_load(id_is_load), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   typedef struct { int idx; logic [4:0] ctrl; } ctrl_exp_t;
   typedef struct { int idx; logic [1:0] fa; logic [1:0] fb; logic [1:0] st;
                    logic [CNT_W-1:0] sc; logic [CNT_W-1:0] fc; } reg_exp_t;

   ctrl_exp_t ctrl_q[$];
   reg_exp_t  reg_q[$];
   int errors = 0;
   int checks = 0;
   int step_no = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_regs();
      reg_exp_t r;
      r = reg_q.pop_front();
      chk($sformatf("s%0d_fwd_a", r.idx), 16'(fwd_a), 16'(r.fa));
      chk($sformatf("s%0d_fwd_b", r.idx), 16'(fwd_b), 16'(r.fb));
      chk($sformatf("s%0d_state", r.idx), 16'(ctrl_state), 16'(r.st));
      chk($sformatf("s%0d_stall_cnt", r.idx), 16'(stall_cnt), 16'(r.sc));
      chk($sformatf("s%0d_flush_cnt", r.idx), 16'(flush_cnt), 16'(r.fc));
   endtask

   task automatic set_id(input logic v, input int rs1, input int rs2, input logic u1,
                         input logic u2, input int rd, input logic wb, input logic ld);
      id_valid   = v;
      id_rs1     = REG_W'(rs1);
      id_rs2     = REG_W'(rs2);
      id_use_rs1 = u1;
      id_use_rs2 = u2;
      id_rd      = REG_W'(rd);
      id_reg_wb  = wb;
      id_is_load = ld;
   endtask

   // One cycle: drive, check controls and the previous edge's registers, queue next expectation
   task automatic step(input logic redir, input logic busy, input logic rst,
                       input logic [4:0] ectrl, input int fa, input int fb, input int st,
                       input int sc, input int fc);
      ctrl_exp_t c;
      reg_exp_t  r;
      step_no++;
      ex_redirect = redir;
      mem_busy    = busy;
      reset       = rst;
      c.idx  = step_no;
      c.ctrl = ectrl;
      ctrl_q.push_back(c);
      #2;
      if (reg_q.size() > 0) check_regs();
      c = ctrl_q.pop_front();
      chk($sformatf("s%0d_ctrl", c.idx),
          16'({pc_stall, ifid_stall, ifid_flush, idex_bubble, freeze}), 16'(c.ctrl));
      r.idx = step_no;
      r.fa  = 2'(fa);
      r.fb  = 2'(fb);
      r.st  = 2'(st);
      r.sc  = CNT_W'(sc);
      r.fc  = CNT_W'(fc);
      reg_q.push_back(r);
      @(posedge clk);
      #1;
   endtask

   function automatic int sat(input int x);
      return (x > 15) ? 15 : x;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      ex_redirect = 1'b0;
      mem_busy    = 1'b0;
      reset       = 1'b1;
      step(0, 0, 1, C0, 0, 0, 0, 0, 0);
      step(0, 0, 1, C0, 0, 0, 0, 0, 0);
      // load-use: lw x5 then add x6,x5,x1
      set_id(1, 0, 0, 0, 0, 5, 1, 1);   step(0, 0, 0, C0,  0, 0, 0, 0, 0);
      set_id(1, 5, 1, 1, 1, 6, 1, 0);   step(0, 0, 0, STL, 0, 0, 1, 1, 0);
      step(0, 0, 0, C0, 1, 0, 0, 1, 0);
      // ALU forward back-to-back, then with one-instruction gap
      set_id(1, 0, 0, 0, 0, 5, 1, 0);   step(0, 0, 0, C0, 0, 0, 0, 1, 0);
      set_id(1, 5, 5, 1, 1, 7, 1, 0);   step(0, 0, 0, C0, 2, 2, 0, 1, 0);
      set_id(1, 0, 0, 0, 0, 9, 1, 0);   step(0, 0, 0, C0, 0, 0, 0, 1, 0);
      set_id(0, 0, 0, 0, 0, 0, 0, 0);   step(0, 0, 0, C0, 0, 0, 0, 1, 0);
      set_id(1, 9, 9, 1, 1, 10, 1, 0);  step(0, 0, 0, C0, 1, 1, 0, 1, 0);
      // redirect squashes the ID instruction
      set_id(1, 10, 10, 1, 1, 11, 1, 0); step(1, 0, 0, FLS, 0, 0, 2, 1, 1);
      set_id(1, 11, 11, 1, 1, 12, 1, 0); step(0, 0, 0, C0,  0, 0, 0, 1, 1);
      // mem_busy beats redirect and load-use; redirect serviced when busy drops
      set_id(1, 0, 0, 0, 0, 13, 1, 1);  step(0, 0, 0, C0, 0, 0, 0, 1, 1);
      set_id(1, 13, 0, 1, 0, 14, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 1, 0, FRZ, 0, 0, 3, 1, 1);
      step(1, 0, 0, FLS, 0, 0, 2, 1, 2);
      // x0 never stalls or forwards
      set_id(1, 0, 0, 0, 0, 0, 1, 1);   step(0, 0, 0, C0, 0, 0, 0, 1, 2);
      set_id(1, 0, 0, 1, 1, 1, 1, 0);   step(0, 0, 0, C0, 0, 0, 0, 1, 2);
      set_id(1, 0, 0, 1, 1, 2, 1, 0);   step(0, 0, 0, C0, 0, 0, 0, 1, 2);
      // counter saturation
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 15; i++) step(1, 0, 0, FLS, 0, 0, 2, 1, sat(2 + i));
      for (int i = 1; i <= 15; i++) begin
         set_id(1, 0, 0, 0, 0, 5, 1, 1);  step(0, 0, 0, C0,  0, 0, 0, sat(i), 15);
         set_id(1, 5, 0, 1, 0, 6, 1, 0);  step(0, 0, 0, STL, 0, 0, 1, sat(i + 1), 15);
      end
      // reset while frozen
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, FRZ, 0, 0, 3, 15, 15);
      step(0, 1, 1, C0, 0, 0, 0, 0, 0);
      step(0, 0, 0, C0, 0, 0, 0, 0, 0);
      #2;
      while (reg_q.size() > 0) check_regs();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
